// File: rtl/pipe_skid_reg_pkg.sv
// Shared state encodings for pipe_skid_reg.
// PIPE_SKID_EN selects the skid-buffer build; the default build is hold-only.
package pipe_skid_reg_pkg;

  typedef enum logic [1:0] {
    PIPE_ST_EMPTY = 2'b00,
    PIPE_ST_BUSY  = 2'b01,
    PIPE_ST_FULL  = 2'b10
  } pipe_st_e;

endpackage

// File: rtl/gnrl_dff.sv
// Generic write-enabled payload register with asynchronous active-low reset.
module gnrl_dff #(
  parameter int            DW         = 32,
  parameter logic [DW-1:0] data_r_ini = {DW{1'b0}}
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [DW-1:0] data_in,
  output logic [DW-1:0] data_r
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r <= data_r_ini;
    end else if (wr_en) begin
      data_r <= data_in;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake and synchronous flush.
// Defining PIPE_SKID_EN adds a skid entry and makes ready_o a pure register.
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int            DW      = 64,
  parameter logic [DW-1:0] RST_VAL = {DW{1'b0}}
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          valid_i,
  output logic          ready_o,
  input  logic [DW-1:0] data_i,
  output logic          valid_o,
  input  logic          ready_i,
  output logic [DW-1:0] data_o
);

  logic          in_fire_s;
  logic          out_fire_s;
  logic          main_we_s;
  logic [DW-1:0] main_din_s;
  logic          valid_q;
  logic          valid_d;

  assign in_fire_s  = valid_i & ready_o;
  assign out_fire_s = valid_q & ready_i;
  assign valid_o    = valid_q;

`ifdef PIPE_SKID_EN
  pipe_st_e      state_q;
  pipe_st_e      state_d;
  logic          ready_q;
  logic          ready_d;
  logic          skid_we_s;
  logic          main_from_skid_s;
  logic [DW-1:0] skid_din_s;
  logic [DW-1:0] skid_q;

  assign ready_o = ready_q;

  always_comb begin
    state_d          = state_q;
    main_we_s        = 1'b0;
    skid_we_s        = 1'b0;
    main_from_skid_s = 1'b0;
    case (state_q)
      PIPE_ST_EMPTY: begin
        if (in_fire_s) begin
          main_we_s = 1'b1;
          state_d   = PIPE_ST_BUSY;
        end else begin
          state_d = PIPE_ST_EMPTY;
        end
      end
      PIPE_ST_BUSY: begin
        if (in_fire_s && out_fire_s) begin
          main_we_s = 1'b1;
        end else if (in_fire_s) begin
          skid_we_s = 1'b1;
          state_d   = PIPE_ST_FULL;
        end else if (out_fire_s) begin
          state_d = PIPE_ST_EMPTY;
        end else begin
          state_d = PIPE_ST_BUSY;
        end
      end
      PIPE_ST_FULL: begin
        if (ready_i) begin
          main_we_s        = 1'b1;
          main_from_skid_s = 1'b1;
          state_d          = PIPE_ST_BUSY;
        end else begin
          state_d = PIPE_ST_FULL;
        end
      end
      default: begin
        state_d = PIPE_ST_EMPTY;
      end
    endcase
    // Flush overrides everything; both payload registers reload RST_VAL.
    if (flush_i) begin
      state_d   = PIPE_ST_EMPTY;
      main_we_s = 1'b1;
      skid_we_s = 1'b1;
    end else begin
      state_d = state_d;
    end
  end

  assign valid_d    = (state_d != PIPE_ST_EMPTY);
  assign ready_d    = (state_d != PIPE_ST_FULL);
  assign main_din_s = flush_i ? RST_VAL : (main_from_skid_s ? skid_q : data_i);
  assign skid_din_s = flush_i ? RST_VAL : data_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PIPE_ST_EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  gnrl_dff #(
    .DW         (DW),
    .data_r_ini (RST_VAL)
  ) u_skid_dff (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (skid_we_s),
    .data_in (skid_din_s),
    .data_r  (skid_q)
  );
`else
  assign ready_o = ready_i | ~valid_q;

  always_comb begin
    main_we_s = in_fire_s | flush_i;
    valid_d   = valid_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (in_fire_s) begin
      valid_d = 1'b1;
    end else if (out_fire_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  assign main_din_s = flush_i ? RST_VAL : data_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end
`endif

  gnrl_dff #(
    .DW         (DW),
    .data_r_ini (RST_VAL)
  ) u_main_dff (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (main_we_s),
    .data_in (main_din_s),
    .data_r  (data_o)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: directed scenarios plus random traffic
// compared cycle by cycle against a queue-based model of the stage.
module tb_pipe_skid_reg;

  localparam int DW = 64;
  localparam logic [DW-1:0] RST_VAL = {DW{1'b0}};
`ifdef PIPE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush_i;
  logic          valid_i;
  logic          ready_o;
  logic [DW-1:0] data_i;
  logic          valid_o;
  logic          ready_i;
  logic [DW-1:0] data_o;

  int            n_checks = 0;
  int            n_fail   = 0;

  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_last;

  always #5 clk = ~clk;

  pipe_skid_reg #(.DW(DW), .RST_VAL(RST_VAL)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (data_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o)
  );

  task automatic check_eq(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic model_ready(input logic r);
    if (CAP == 2) return (mq.size() < 2);
    return r || (mq.size() == 0);
  endfunction

  // One clock of traffic: drive, compare against the model, then advance it.
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic r,
                       input logic f, output logic acc);
    logic exp_rdy, exp_vld, in_f, out_f;
    @(negedge clk);
    valid_i = v; data_i = d; ready_i = r; flush_i = f;
    #1;
    exp_vld = (mq.size() != 0);
    exp_rdy = model_ready(r);
    check_eq("valid_o", {63'd0, valid_o}, {63'd0, exp_vld});
    check_eq("ready_o", {63'd0, ready_o}, {63'd0, exp_rdy});
    check_eq("data_o", data_o, m_last);
    in_f  = v & exp_rdy;
    out_f = exp_vld & r;
    acc   = in_f & ~f;
    @(posedge clk);
    if (f) begin
      mq.delete();
      m_last = RST_VAL;
    end else begin
      if (out_f) void'(mq.pop_front());
      if (in_f) mq.push_back(d);
      if (mq.size() != 0) m_last = mq[0];
    end
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 4; i++) cycle(1'b0, 64'd0, 1'b1, 1'b0, acc);
  endtask

  initial begin
    logic          acc;
    logic [DW-1:0] pend[$];
    logic [DW-1:0] next_id;
    int            beats;
    int            cyc;

    rst_n = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0; data_i = 64'd0;
    m_last = RST_VAL;
    #1;
    check_eq("rst_valid", {63'd0, valid_o}, 64'd0);
    check_eq("rst_ready", {63'd0, ready_o}, 64'd1);
    check_eq("rst_data", data_o, RST_VAL);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back streaming with downstream always ready.
    for (int i = 1; i <= 100; i++) begin
      cycle(1'b1, DW'(i), 1'b1, 1'b0, acc);
      check_eq("stream_acc", {63'd0, acc}, 64'd1);
    end
    drain();

    // Stall: 0x11, 0x22, 0x33 with ready_i low from cycle 1 until cycle 5.
    pend = '{64'h11, 64'h22, 64'h33};
    for (int c = 0; c < 14; c++) begin
      if (pend.size() != 0) begin
        cycle(1'b1, pend[0], (c == 0) || (c >= 5), 1'b0, acc);
        if (acc) void'(pend.pop_front());
      end else begin
        cycle(1'b0, 64'd0, 1'b1, 1'b0, acc);
      end
    end
    check_eq("stall_all_sent", 64'(pend.size()), 64'd0);
    drain();

    // Fill the stage, then flush while a new beat 0x44 is offered.
    cycle(1'b1, 64'h55, 1'b0, 1'b0, acc);
    cycle(1'b1, 64'h66, 1'b0, 1'b0, acc);
    check_eq("fill_depth", 64'(mq.size()), 64'(CAP));
    cycle(1'b1, 64'h44, 1'b0, 1'b1, acc);
    #1;
    check_eq("flush_valid", {63'd0, valid_o}, 64'd0);
    check_eq("flush_ready", {63'd0, ready_o}, 64'd1);
    check_eq("flush_data", data_o, RST_VAL);
    drain();

    // Asynchronous reset in the middle of a stream.
    for (int i = 0; i < 3; i++) cycle(1'b1, 64'h200 + 64'(i), 1'b0, 1'b0, acc);
    @(negedge clk);
    valid_i = 1'b1; data_i = 64'hA5A5; ready_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", {63'd0, valid_o}, 64'd0);
    check_eq("mid_rst_ready", {63'd0, ready_o}, 64'd1);
    check_eq("mid_rst_data", data_o, RST_VAL);
    mq.delete();
    m_last  = RST_VAL;
    valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 64'h77, 1'b1, 1'b0, acc);
    #1;
    check_eq("post_rst_valid", {63'd0, valid_o}, 64'd1);
    check_eq("post_rst_data", data_o, 64'h77);
    drain();

    // Random traffic with occasional flushes; ids make loss/duplication visible.
    next_id = 64'h1000;
    beats   = 0;
    cyc     = 0;
    while (beats < 10000 && cyc < 60000) begin
      cycle(1'($urandom_range(0, 1)), next_id, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 199) == 0), acc);
      if (acc) begin
        next_id++;
        beats++;
      end
      cyc++;
    end
    check_eq("rand_budget", {63'd0, (beats >= 10000)}, 64'd1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
